// File: rtl/alu_pkg.sv
// Shared definitions for the alu command/issue path: default sizes, op encoding
// and the command record carried from the command port to the alu.
package alu_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_TAG_W = 2;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic                 op;
        logic [DEF_TAG_W-1:0] tag;
    } cmd_t;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundles the command, alu and response signals of alu_issue_ctrl.
// Handshakes: a transfer happens on a posedge where valid & ready are both high;
// a source holds valid and its payload stable until that transfer.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH,
    parameter int TAG_W = alu_pkg::DEF_TAG_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_op;
    logic [TAG_W-1:0] cmd_tag;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_op;
    logic [WIDTH-1:0] alu_out;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    logic             busy;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_out, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_tag, busy
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_out, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_tag, busy
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head; pushes while full and pops while
// empty are ignored, so the full flag never depends on a same-cycle pop.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Command stage in front of a 1-cycle registered alu: queues tagged commands,
// issues against result-buffer credit, and returns results in order.
module alu_issue_ctrl #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH,
    parameter int DEPTH = alu_pkg::DEF_DEPTH,
    parameter int TAG_W = alu_pkg::DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus
);
    import alu_pkg::*;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             op;
        logic [TAG_W-1:0] tag;
    } q_entry_t;

    localparam int QW = $bits(q_entry_t);

    q_entry_t         w_push_data;
    q_entry_t         w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_issue;
    logic             w_rsp_fire;
    logic [2:0]       w_credit;

    logic             r_inflight;
    logic [TAG_W-1:0] r_tag_d;
    logic [WIDTH-1:0] r_rb_data [2];
    logic [TAG_W-1:0] r_rb_tag  [2];
    logic             r_rb_wr;
    logic             r_rb_rd;
    logic [1:0]       r_rb_cnt;

    assign w_push_data = {bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag};

    sync_fifo #(.W(QW), .DEPTH(DEPTH)) u_cmd_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.cmd_valid),
        .i_data  (w_push_data),
        .i_pop   (w_issue),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.cmd_ready = !w_full && !rst;
    assign bus.alu_a     = w_head.a;
    assign bus.alu_b     = w_head.b;
    assign bus.alu_op    = w_head.op;

    // Issue only if the result, one cycle later, is sure to find a buffer slot.
    assign w_rsp_fire = (r_rb_cnt != 2'd0) && bus.rsp_ready;
    assign w_credit   = {1'b0, r_rb_cnt} + {2'b00, r_inflight};
    assign w_issue    = !w_empty && (w_credit <= 3'd1 + {2'b00, w_rsp_fire});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_tag_d    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_tag_d <= w_head.tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rb_wr  <= 1'b0;
            r_rb_rd  <= 1'b0;
            r_rb_cnt <= 2'd0;
        end else begin
            if (r_inflight) r_rb_wr <= ~r_rb_wr;
            if (w_rsp_fire) r_rb_rd <= ~r_rb_rd;
            r_rb_cnt <= r_rb_cnt + {1'b0, r_inflight} - {1'b0, w_rsp_fire};
        end
    end

    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_rb_data[r_rb_wr] <= bus.alu_out;
            r_rb_tag[r_rb_wr]  <= r_tag_d;
        end
    end

    assign bus.rsp_valid = (r_rb_cnt != 2'd0);
    assign bus.rsp_data  = r_rb_data[r_rb_rd];
    assign bus.rsp_tag   = r_rb_tag[r_rb_rd];
    assign bus.busy      = !w_empty || r_inflight || (r_rb_cnt != 2'd0);

    a_no_rb_overflow: assert property (@(posedge clk) disable iff (rst)
        !(r_inflight && (r_rb_cnt == 2'd2) && !w_rsp_fire));
endmodule
